// File: rtl/ringosc_meas_pkg.sv
// rtl/ringosc_meas_pkg.sv - shared state encoding and default sizing for the ring oscillator measurement controller
package ringosc_meas_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      MEASURE,
      STOP,
      DONE
   } meas_state_t;

   localparam int DEF_WINDOW_W      = 16;
   localparam int DEF_COUNT_W       = 16;
   localparam int DEF_SETTLE_CYCLES = 16;
   localparam int DEF_NTAPS         = 16;

endpackage

// File: rtl/ringosc_tap_sync.sv
// rtl/ringosc_tap_sync.sv - two-flop synchronizer for one divider tap plus edge-detect flop giving a rising-edge pulse
module ringosc_tap_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic tap,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= tap;
         sync <= meta;
         prev <= sync;
      end
   end

   // Built only from flop outputs, so the pulse is glitch-free for the counter.
   assign rise = sync & ~prev;

endmodule

// File: rtl/ringosc_meas_ctrl.sv
// rtl/ringosc_meas_ctrl.sv - ring oscillator edge-count controller; optional autorun loop under RINGOSC_MEAS_AUTORUN_EN
module ringosc_meas_ctrl
   import ringosc_meas_pkg::*;
#(
   parameter int WINDOW_W      = DEF_WINDOW_W,
   parameter int COUNT_W       = DEF_COUNT_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int NTAPS         = DEF_NTAPS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [WINDOW_W-1:0]      window_len,
   input  logic [$clog2(NTAPS)-1:0] tap_sel,
   input  logic [NTAPS-1:0]         div_taps,
   input  logic                     result_ack,
`ifdef RINGOSC_MEAS_AUTORUN_EN
   input  logic                     autorun,
`endif
   output logic                     ring_en,
   output logic                     div_rst_n,
   output logic                     busy,
   output logic                     result_valid,
   output logic [COUNT_W-1:0]       result,
   output logic                     overflow
);

   localparam int TAP_W    = $clog2(NTAPS);
   localparam int SETTLE_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

   meas_state_t         state;
   meas_state_t         state_n;
   logic                accept;
   logic                load_settle;
   logic [WINDOW_W-1:0] win_q;
   logic [TAP_W-1:0]    tap_q;
   logic [WINDOW_W-1:0] win_cnt;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [COUNT_W-1:0]  cnt;
   logic                ovf;
   logic                tap_rise;
   logic                settle_done;
   logic                window_done;

   ringosc_tap_sync u_tap_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .tap  (div_taps[tap_q]),
      .rise (tap_rise)
   );

   assign settle_done = (settle_cnt == '0);
   assign window_done = (win_cnt == WINDOW_W'(1));

   always_comb begin
      state_n     = state;
      accept      = 1'b0;
      load_settle = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept      = 1'b1;
               load_settle = 1'b1;
               state_n     = SETTLE;
            end
         end
         SETTLE: begin
            if (abort)            state_n = IDLE;
            else if (settle_done) state_n = MEASURE;
         end
         MEASURE: begin
            if (abort)            state_n = IDLE;
            else if (window_done) state_n = STOP;
         end
         STOP: state_n = DONE;
         DONE: begin
            if (start) begin
               accept      = 1'b1;
               load_settle = 1'b1;
               state_n     = SETTLE;
            end else if (result_ack) begin
               state_n = IDLE;
`ifdef RINGOSC_MEAS_AUTORUN_EN
               if (autorun) begin
                  load_settle = 1'b1;
                  state_n     = SETTLE;
               end
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         win_q        <= '0;
         tap_q        <= '0;
         win_cnt      <= '0;
         settle_cnt   <= '0;
         cnt          <= '0;
         ovf          <= 1'b0;
         ring_en      <= 1'b0;
         div_rst_n    <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         overflow     <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            win_q <= (window_len == '0) ? WINDOW_W'(1) : window_len;
            tap_q <= tap_sel;
         end
         if (load_settle) begin
            settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
            cnt        <= '0;
            ovf        <= 1'b0;
         end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
         end
         // Window reload at the end of settle also serves autorun re-entry.
         if (state == SETTLE && settle_done) win_cnt <= win_q;
         else if (state == MEASURE)          win_cnt <= win_cnt - WINDOW_W'(1);
         if (state == MEASURE && tap_rise) begin
            if (cnt == '1) ovf <= 1'b1;
            else           cnt <= cnt + COUNT_W'(1);
         end
         ring_en      <= (state == SETTLE) || (state == MEASURE);
         div_rst_n    <= (state == SETTLE) || (state == MEASURE);
         busy         <= (state == SETTLE) || (state == MEASURE) || (state == STOP);
         result_valid <= (state == DONE);
         result       <= cnt;
         overflow     <= ovf;
      end
   end

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// tb/tb_ringosc_meas_ctrl.sv - randomized self-checking bench for ringosc_meas_ctrl against an edge-count model
module tb_ringosc_meas_ctrl;

   localparam int S = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        result_ack = 1'b0;
   logic [15:0] window_len = '0;
   logic [3:0]  tap_sel = '0;
   logic [15:0] div_taps = '0;
`ifdef RINGOSC_MEAS_AUTORUN_EN
   logic        autorun = 1'b0;
`endif
   logic        ring_en, div_rst_n, busy, result_valid, overflow;
   logic [15:0] result;
   logic        ring_en4, div_rst_n4, busy4, result_valid4, overflow4;
   logic [3:0]  result4;

   int total = 0;
   int passed = 0;
   int cyc = 0;
   int tap_period = 0;
   bit [15:0] hist [0:16383];

   ringosc_meas_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .window_len(window_len), .tap_sel(tap_sel), .div_taps(div_taps), .result_ack(result_ack),
`ifdef RINGOSC_MEAS_AUTORUN_EN
      .autorun(autorun),
`endif
      .ring_en(ring_en), .div_rst_n(div_rst_n), .busy(busy),
      .result_valid(result_valid), .result(result), .overflow(overflow)
   );

   ringosc_meas_ctrl #(.COUNT_W(4), .SETTLE_CYCLES(S)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .window_len(window_len), .tap_sel(tap_sel), .div_taps(div_taps), .result_ack(result_ack),
`ifdef RINGOSC_MEAS_AUTORUN_EN
      .autorun(autorun),
`endif
      .ring_en(ring_en4), .div_rst_n(div_rst_n4), .busy(busy4),
      .result_valid(result_valid4), .result(result4), .overflow(overflow4)
   );

   always #5 clk = ~clk;

   // Taps change just after each edge; hist[n] is the value sampled at edge n+1.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (tap_period == 0) div_taps = div_taps ^ 16'($urandom);
      else div_taps = (((cyc / (tap_period / 2)) % 2) != 0) ? 16'hFFFF : 16'h0000;
      if (cyc < 16384) hist[cyc] = div_taps;
   end

   // Rising edges of the tap that land in the effective window: the
   // three-flop path shifts the window by two cycles and drops the last two.
   function automatic int model_raw(input int se, input int sel, input int win);
      int w = (win == 0) ? 1 : win;
      int c = 0;
      for (int n = S - 2; n <= S + w - 3; n++)
         if (hist[se + n][sel] && !hist[se + n - 1][sel]) c++;
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] win, input logic [3:0] sel, output int se);
      window_len = win;
      tap_sel = sel;
      start = 1'b1;
      se = cyc + 1;
      step();
      start = 1'b0;
      window_len = 16'($urandom);
      tap_sel = 4'($urandom);
   endtask

   task automatic wait_valid(input int budget, output int ve);
      ve = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (result_valid === 1'b1) begin
            ve = cyc;
            break;
         end
      end
   endtask

   task automatic do_ack();
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      total++; if (ring_en !== 1'b0) $display("FAIL reset_ring_en: got %b want 0", ring_en); else passed++;
      total++; if (div_rst_n !== 1'b0) $display("FAIL reset_div_rst_n: got %b want 0", div_rst_n); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid: got %b want 0", result_valid); else passed++;
      total++; if (result !== 16'h0) $display("FAIL reset_result: got %0d want 0", result); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
   endtask

   task automatic test_basic();
      int se;
      logic exp_en, exp_v;
      tap_period = 8;
      repeat (4) step();
      do_start(16'd64, 4'd3, se);
      for (int e = se + 1; e <= se + 2 + S + 64; e++) begin
         step();
         exp_en = (e <= se + S + 64);
         exp_v = (e == se + 2 + S + 64);
         total++; if (ring_en !== exp_en) $display("FAIL basic_ring_en edge %0d: got %b want %b", e - se, ring_en, exp_en); else passed++;
         total++; if (result_valid !== exp_v) $display("FAIL basic_valid edge %0d: got %b want %b", e - se, result_valid, exp_v); else passed++;
      end
      total++; if (result !== 16'd8) $display("FAIL basic_result: got %0d want 8", result); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL basic_overflow: got %b want 0", overflow); else passed++;
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      total++; if (result_valid !== 1'b1) $display("FAIL ack_same_edge: got %b want 1", result_valid); else passed++;
      step();
      total++; if (result_valid !== 1'b0) $display("FAIL ack_next_edge: got %b want 0", result_valid); else passed++;
   endtask

   task automatic test_overflow();
      int se, ve, exp;
      tap_period = 4;
      repeat (4) step();
      do_start(16'd100, 4'd3, se);
      wait_valid(400, ve);
      exp = model_raw(se, 3, 100);
      total++; if (ve != se + 2 + S + 100) $display("FAIL ovf_latency: got %0d want %0d", ve - se, 2 + S + 100); else passed++;
      total++; if (result4 !== 4'd15) $display("FAIL ovf_result4: got %0d want 15", result4); else passed++;
      total++; if (overflow4 !== 1'b1) $display("FAIL ovf_flag4: got %b want 1", overflow4); else passed++;
      total++; if (result !== 16'(exp)) $display("FAIL ovf_result16: got %0d want %0d", result, exp); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL ovf_flag16: got %b want 0", overflow); else passed++;
      do_ack();
      tap_period = 0;
   endtask

   task automatic test_abort();
      int se;
      bit seen = 0;
      do_start(16'd64, 4'($urandom), se);
      repeat (S + 9) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();
      total++; if (ring_en !== 1'b0) $display("FAIL abort_ring_en: got %b want 0", ring_en); else passed++;
      total++; if (div_rst_n !== 1'b0) $display("FAIL abort_div_rst_n: got %b want 0", div_rst_n); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
      for (int i = 0; i < 120; i++) begin
         step();
         if (result_valid !== 1'b0) seen = 1;
      end
      total++; if (seen) $display("FAIL abort_no_result: got valid 1 want 0"); else passed++;
   endtask

   task automatic test_back_to_back();
      int se, ve, exp, w, sel;
      w = $urandom_range(20, 60);
      sel = $urandom_range(0, 15);
      do_start(16'(w), 4'(sel), se);
      repeat (S + 5) step();
      start = 1'b1;
      window_len = 16'd7;
      step();
      start = 1'b0;
      wait_valid(300, ve);
      exp = model_raw(se, sel, w);
      total++; if (ve != se + 2 + S + w) $display("FAIL ignored_start_latency: got %0d want %0d", ve - se, 2 + S + w); else passed++;
      total++; if (result !== 16'(exp)) $display("FAIL ignored_start_result: got %0d want %0d", result, exp); else passed++;
      w = $urandom_range(5, 40);
      sel = $urandom_range(0, 15);
      do_start(16'(w), 4'(sel), se);
      step();
      total++; if (result_valid !== 1'b0) $display("FAIL done_start_valid_drop: got %b want 0", result_valid); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL done_start_busy: got %b want 1", busy); else passed++;
      wait_valid(300, ve);
      exp = model_raw(se, sel, w);
      total++; if (ve != se + 2 + S + w) $display("FAIL done_start_latency: got %0d want %0d", ve - se, 2 + S + w); else passed++;
      total++; if (result !== 16'(exp)) $display("FAIL done_start_result: got %0d want %0d", result, exp); else passed++;
      do_ack();
   endtask

   task automatic test_window_zero();
      int se, ve, exp, sel;
      sel = $urandom_range(0, 15);
      do_start(16'd0, 4'(sel), se);
      wait_valid(100, ve);
      exp = model_raw(se, sel, 1);
      total++; if (ve != se + 19) $display("FAIL win0_latency: got %0d want 19", ve - se); else passed++;
      total++; if (result !== 16'(exp)) $display("FAIL win0_result: got %0d want %0d", result, exp); else passed++;
      do_ack();
   endtask

   task automatic test_random();
      int se, ve, exp, w, sel;
      for (int it = 0; it < 6; it++) begin
         w = $urandom_range(1, 150);
         sel = $urandom_range(0, 15);
         do_start(16'(w), 4'(sel), se);
         wait_valid(w + S + 20, ve);
         exp = model_raw(se, sel, w);
         total++; if (ve != se + 2 + S + w) $display("FAIL rand%0d_latency: got %0d want %0d", it, ve - se, 2 + S + w); else passed++;
         total++; if (result !== 16'(exp)) $display("FAIL rand%0d_result: got %0d want %0d", it, result, exp); else passed++;
         total++; if (overflow !== 1'b0) $display("FAIL rand%0d_overflow: got %b want 0", it, overflow); else passed++;
         repeat ($urandom_range(0, 3)) step();
         do_ack();
      end
   endtask

   task automatic test_reset_mid_settle();
      int se;
      do_start(16'd50, 4'($urandom), se);
      repeat (4) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total++; if (ring_en !== 1'b0) $display("FAIL midrst_ring_en: got %b want 0", ring_en); else passed++;
      total++; if (div_rst_n !== 1'b0) $display("FAIL midrst_div_rst_n: got %b want 0", div_rst_n); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
      total++; if (result_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", result_valid); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL midrst_overflow: got %b want 0", overflow); else passed++;
      repeat (40) step();
      total++; if (busy !== 1'b0 || result_valid !== 1'b0) $display("FAIL midrst_stays_idle: got busy %b valid %b want 0 0", busy, result_valid); else passed++;
   endtask

`ifdef RINGOSC_MEAS_AUTORUN_EN
   task automatic test_autorun();
      int se, ve, exp, w, sel, k;
      w = $urandom_range(10, 40);
      sel = $urandom_range(0, 15);
      autorun = 1'b1;
      do_start(16'(w), 4'(sel), se);
      wait_valid(200, ve);
      total++; if (ve != se + 2 + S + w) $display("FAIL auto_first_latency: got %0d want %0d", ve - se, 2 + S + w); else passed++;
      result_ack = 1'b1;
      k = cyc + 1;
      step();
      result_ack = 1'b0;
      step();
      total++; if (ring_en !== 1'b1) $display("FAIL auto_reenter_ring_en: got %b want 1", ring_en); else passed++;
      total++; if (result_valid !== 1'b0) $display("FAIL auto_reenter_valid: got %b want 0", result_valid); else passed++;
      wait_valid(200, ve);
      exp = model_raw(k, sel, w);
      total++; if (ve != k + 2 + S + w) $display("FAIL auto_second_latency: got %0d want %0d", ve - k, 2 + S + w); else passed++;
      total++; if (result !== 16'(exp)) $display("FAIL auto_second_result: got %0d want %0d", result, exp); else passed++;
      autorun = 1'b0;
      do_ack();
      total++; if (busy !== 1'b0 || result_valid !== 1'b0) $display("FAIL auto_exit: got busy %b valid %b want 0 0", busy, result_valid); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_abort();
      test_back_to_back();
      test_window_zero();
      test_random();
      test_reset_mid_settle();
`ifdef RINGOSC_MEAS_AUTORUN_EN
      test_autorun();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ringosc_meas_ctrl.md
# ringosc_meas_ctrl

Measurement controller for the gated ring oscillator and its 16-stage ripple divider. It enables the ring and releases the divider, then counts rising edges of one selected divider tap over a programmable window of `clk` cycles. It parks the oscillator when the measurement ends and presents the edge count through a valid/ack handshake. It sits between the host-side control inputs and the oscillator/divider macro: `ring_en` drives the ring enable, `div_rst_n` drives the divider reset.

## Interface
Parameters:
- `WINDOW_W`, 16, width of measurement window length
- `COUNT_W`, 16, width of result counter
- `SETTLE_CYCLES`, 16, cycles between ring enable and start of counting (≥3)
- `NTAPS`, 16, number of divider taps presented on `div_taps`

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request a measurement
- `abort`  in  1  cancel measurement in progress, no result
- `window_len`  in  WINDOW_W  measurement window in `clk` cycles, sampled on start acceptance
- `tap_sel`  in  $clog2(NTAPS)  divider tap to count, sampled on start acceptance
- `div_taps`  in  NTAPS  divider Q outputs, asynchronous to `clk`
- `result_ack`  in  1  consumer accepts result
- `ring_en`  out  1  oscillator enable
- `div_rst_n`  out  1  divider reset, active-low
- `busy`  out  1  measurement in progress
- `result_valid`  out  1  result available
- `result`  out  COUNT_W  rising-edge count
- `overflow`  out  1  count saturated

## Operation
- States: IDLE, SETTLE, MEASURE, STOP, DONE.
- IDLE: `ring_en`=0, `div_rst_n`=0, `busy`=0. `start`=1 latches `window_len` and `tap_sel`, clears counter and `overflow`, and moves to SETTLE. A `window_len` of 0 is coerced to 1.
- SETTLE: `ring_en`=1, `div_rst_n`=1, `busy`=1. Runs exactly SETTLE_CYCLES cycles, which fills the synchronizer, then moves to MEASURE.
- MEASURE: runs exactly latched-window cycles. In each cycle, the counter increments when the synchronized tap rises, detected as current=1 and previous=0. The counter saturates at all-ones and sets `overflow`, which is sticky until the next start.
- STOP: 1 cycle. `ring_en`=0, `div_rst_n`=0, `busy`=1. The counter is frozen.
- DONE: `result_valid`=1 and `busy`=0; `result` and `overflow` hold steady.
  - `result_ack`=1 returns to IDLE.
  - `start`=1 (with or without ack) implicitly acks the result and goes directly to SETTLE with new latched config.
- `abort`=1 in SETTLE or MEASURE goes to IDLE on the next edge. No result is produced and the previous result is not restored. `abort` is ignored in IDLE, STOP and DONE.
- `start` while `busy`=1 is ignored. `abort` has priority over `start`.
- Tap selection is not range-checked beyond the index width. Counting is valid only for tap frequency below clk/2; this is the caller's responsibility.
- Reset values: state IDLE, `ring_en`=0, `div_rst_n`=0, `busy`=0, `result_valid`=0, `result`=0, `overflow`=0.
- Reset asserted mid-measurement returns everything to reset values on the next edge and stops the ring immediately.

## Timing
- All outputs are registered.
- With `start` sampled at edge 0:
  - SETTLE occupies cycles 1..SETTLE_CYCLES.
  - MEASURE occupies the next window_len cycles.
  - STOP follows.
  - `result_valid` rises at edge 2+SETTLE_CYCLES+window_len.
- `result_ack` sampled at edge k drops `result_valid` at edge k+1.
- Tap path is a 2-flop synchronizer plus 1 edge-detect flop. Edges arriving in the last 2 MEASURE cycles are lost; this is accepted error.

## Configuration
- `RINGOSC_MEAS_AUTORUN_EN` defined:
  - Adds input `autorun` (1 bit).
  - When `autorun`=1 in DONE and `result_ack`=1, the block re-enters SETTLE on the next edge using the previously latched window/tap, rather than going to IDLE.
  - `abort` and reset exit the loop.
- Undefined: port absent; DONE+ack always goes to IDLE.

## Structure
- Package `ringosc_meas_pkg`: state enum (IDLE, SETTLE, MEASURE, STOP, DONE), default width constants, SETTLE_CYCLES default.
- Sub-module `ringosc_tap_sync`: 2-flop synchronizer with registered rising-edge pulse output, synchronous active-low reset to 0.
- Top holds FSM, window down-counter, saturating result counter.

## Test plan
- Bench drives `div_taps[3]` as a square wave of period 8 clk, `tap_sel`=3, `window_len`=64, SETTLE_CYCLES=16, `start` at edge 0 -> `result_valid` rises at edge 82 with `result`=8, `overflow`=0; `ring_en` high edges 1..80.
- COUNT_W=4, tap period 4, `window_len`=100 -> `result`=15, `overflow`=1.
- `abort` asserted 10 cycles into MEASURE -> next edge IDLE, `ring_en`=0, `div_rst_n`=0, `result_valid` stays 0.
- `start` pulsed during MEASURE -> ignored, latency and result unchanged; `start` in DONE -> `result_valid` drops next edge, new measurement runs.
- `window_len`=0 -> behaves as 1; `result_valid` at edge 2+SETTLE_CYCLES+1 = 19.
- `rst_n` low for 1 cycle mid-SETTLE -> all outputs at reset values next edge. With `RINGOSC_MEAS_AUTORUN_EN`, `autorun`=1 plus ack -> SETTLE next edge with same window.
